// File: rtl/cv32e40s_obi_arbiter.sv
// Two-requester OBI arbiter: round-robin with address-phase lock, zero-latency grant,
// response routing through an in-order ID FIFO bounded by MAX_OUTSTANDING.
module cv32e40s_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  m_req_i,
  output logic [1:0]  m_gnt_o,
  input  logic [63:0] m_addr_i,
  input  logic [1:0]  m_we_i,
  input  logic [7:0]  m_be_i,
  input  logic [63:0] m_wdata_i,
  output logic [1:0]  m_rvalid_o,
  output logic        obi_req_o,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_gnt_i,
  input  logic        obi_rvalid_i,
  output logic        protocol_err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                       sel_q;
  logic                       lock_q;
  logic                       prio_q;
  logic [CW-1:0]              cnt_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wr_ptr_q;
  logic [PW-1:0]              rd_ptr_q;

  logic          sel;
  logic          below_max;
  logic          accept;
  logic          pop;
  logic          head;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;

  // A locked request must be presented unchanged until granted.
  always_comb begin
    sel = prio_q;
    if (lock_q)                sel = sel_q;
    else if (m_req_i == 2'b01) sel = 1'b0;
    else if (m_req_i == 2'b10) sel = 1'b1;
  end

  assign below_max = (cnt_q < CW'(MAX_OUTSTANDING));
  assign obi_req_o = lock_q | ((|m_req_i) & below_max);
  assign accept    = obi_req_o & obi_gnt_i;
  assign pop       = obi_rvalid_i & (cnt_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  assign obi_addr_o  = !obi_req_o ? '0 : (sel ? m_addr_i[63:32]  : m_addr_i[31:0]);
  assign obi_we_o    = !obi_req_o ? '0 : (sel ? m_we_i[1]        : m_we_i[0]);
  assign obi_be_o    = !obi_req_o ? '0 : (sel ? m_be_i[7:4]      : m_be_i[3:0]);
  assign obi_wdata_o = !obi_req_o ? '0 : (sel ? m_wdata_i[63:32] : m_wdata_i[31:0]);

  assign m_gnt_o        = accept ? {sel, ~sel} : 2'b00;
  assign m_rvalid_o     = pop ? {head, ~head} : 2'b00;
  assign protocol_err_o = obi_rvalid_i & (cnt_q == '0);

  assign wr_nxt = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_nxt = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= 1'b0;
      lock_q   <= 1'b0;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept) begin
        lock_q           <= 1'b0;
        prio_q           <= ~sel;
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_nxt;
      end else if (obi_req_o) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
      if (pop) rd_ptr_q <= rd_nxt;
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40s_obi_arbiter.sv
// Bench for cv32e40s_obi_arbiter: directed scenarios, response IDs checked against a
// scoreboard queue filled whenever a grant is expected.
module tb_cv32e40s_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_req = 2'b00;
  logic [1:0]  m_gnt;
  logic [63:0] m_addr = {32'hB000_0004, 32'hA000_0000};
  logic [1:0]  m_we = 2'b10;
  logic [7:0]  m_be = {4'hC, 4'h3};
  logic [63:0] m_wdata = {32'h2222_2222, 32'h1111_1111};
  logic [1:0]  m_rvalid;
  logic        obi_req;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_gnt = 1'b0;
  logic        obi_rvalid = 1'b0;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;
  bit sb[$];
  bit exp_id;
  logic [1:0] exp_rv;

  cv32e40s_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid),
    .obi_req_o(obi_req), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
    .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
    .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid), .protocol_err_o(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv);
    m_req = req; obi_gnt = gnt; obi_rvalid = rv;
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if ({obi_req, m_gnt, m_rvalid, protocol_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {obi_req, m_gnt, m_rvalid, protocol_err});
    end
    checks++;
    if ({obi_addr, obi_we, obi_be, obi_wdata} !== 69'b0) begin
      errors++; $display("FAIL reset_bus: got %h want 0", {obi_addr, obi_we, obi_be, obi_wdata});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [3] = '{2'b01, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b1, i != 0);
      if (i != 0) begin
        exp_id = sb.pop_front();
        exp_rv = exp_id ? 2'b10 : 2'b01;
        checks++;
        if (m_rvalid !== exp_rv) begin
          errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, m_rvalid, exp_rv);
        end
      end
      checks++;
      if (m_gnt !== exp_gnt[i]) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, m_gnt, exp_gnt[i]);
      end
      checks++;
      if (obi_addr !== (exp_gnt[i][1] ? 32'hB000_0004 : 32'hA000_0000) ||
          obi_be !== (exp_gnt[i][1] ? 4'hC : 4'h3) || obi_we !== exp_gnt[i][1]) begin
        errors++; $display("FAIL rr_bus[%0d]: got addr %h be %h we %b", i, obi_addr, obi_be, obi_we);
      end
      sb.push_back(exp_gnt[i][1]);
      tick();
    end
    drive(2'b00, 1'b0, 1'b1);
    exp_id = sb.pop_front();
    exp_rv = exp_id ? 2'b10 : 2'b01;
    checks++;
    if (m_rvalid !== exp_rv || obi_req !== 1'b0) begin
      errors++; $display("FAIL rr_drain: got rvalid %b req %b want %b 0", m_rvalid, obi_req, exp_rv);
    end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      // Second cycle retracts the request; the locked transfer must stay on the bus.
      drive(i == 0 ? 2'b10 : 2'b00, 1'b0, 1'b0);
      checks++;
      if (obi_req !== 1'b1 || m_gnt !== 2'b00 || obi_addr !== 32'hB000_0004) begin
        errors++; $display("FAIL lock_hold[%0d]: got req %b gnt %b addr %h", i, obi_req, m_gnt, obi_addr);
      end
      tick();
    end
    drive(2'b11, 1'b1, 1'b0);
    checks++;
    if (m_gnt !== 2'b10 || obi_addr !== 32'hB000_0004 || obi_wdata !== 32'h2222_2222) begin
      errors++; $display("FAIL lock_gnt: got gnt %b addr %h wdata %h want 10 b0000004 22222222", m_gnt, obi_addr, obi_wdata);
    end
    sb.push_back(1'b1);
    tick();
    drive(2'b00, 1'b0, 1'b1);
    exp_id = sb.pop_front();
    exp_rv = exp_id ? 2'b10 : 2'b01;
    checks++;
    if (m_rvalid !== exp_rv) begin
      errors++; $display("FAIL lock_rvalid: got %b want %b", m_rvalid, exp_rv);
    end
    tick();
  endtask

  task automatic test_outstanding();
    do_reset();
    drive(2'b01, 1'b1, 1'b0); sb.push_back(1'b0); tick();
    drive(2'b10, 1'b1, 1'b0); sb.push_back(1'b1); tick();
    drive(2'b11, 1'b1, 1'b0);
    checks++;
    if (obi_req !== 1'b0 || m_gnt !== 2'b00) begin
      errors++; $display("FAIL full_block: got req %b gnt %b want 0 00", obi_req, m_gnt);
    end
    tick();
    drive(2'b11, 1'b1, 1'b1);
    exp_id = sb.pop_front();
    exp_rv = exp_id ? 2'b10 : 2'b01;
    checks++;
    if (m_rvalid !== exp_rv || obi_req !== 1'b0 || m_gnt !== 2'b00) begin
      errors++; $display("FAIL full_rvalid: got rvalid %b req %b gnt %b want %b 0 00", m_rvalid, obi_req, m_gnt, exp_rv);
    end
    tick();
    drive(2'b11, 1'b1, 1'b0);
    checks++;
    if (obi_req !== 1'b1 || m_gnt !== 2'b01) begin
      errors++; $display("FAIL full_resume: got req %b gnt %b want 1 01", obi_req, m_gnt);
    end
    sb.push_back(1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 1'b0, 1'b1);
      exp_id = sb.pop_front();
      exp_rv = exp_id ? 2'b10 : 2'b01;
      checks++;
      if (m_rvalid !== exp_rv) begin
        errors++; $display("FAIL full_drain[%0d]: got %b want %b", i, m_rvalid, exp_rv);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(2'b01, 1'b1, 1'b0); sb.push_back(1'b0); tick();
    drive(2'b10, 1'b1, 1'b1);
    exp_id = sb.pop_front();
    exp_rv = exp_id ? 2'b10 : 2'b01;
    checks++;
    if (m_rvalid !== exp_rv || m_gnt !== 2'b10) begin
      errors++; $display("FAIL b2b_rvalid: got rvalid %b gnt %b want %b 10", m_rvalid, m_gnt, exp_rv);
    end
    sb.push_back(1'b1);
    tick();
    checks++;
    if (dut.cnt_q !== 2'd1) begin
      errors++; $display("FAIL b2b_cnt: got %0d want 1", dut.cnt_q);
    end
    drive(2'b00, 1'b0, 1'b1);
    exp_id = sb.pop_front();
    exp_rv = exp_id ? 2'b10 : 2'b01;
    checks++;
    if (m_rvalid !== exp_rv || protocol_err !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got rvalid %b err %b want %b 0", m_rvalid, protocol_err, exp_rv);
    end
    tick();
  endtask

  task automatic test_protocol_err();
    do_reset();
    drive(2'b00, 1'b0, 1'b1);
    checks++;
    if (protocol_err !== 1'b1 || m_rvalid !== 2'b00) begin
      errors++; $display("FAIL perr: got err %b rvalid %b want 1 00", protocol_err, m_rvalid);
    end
    tick();
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (dut.cnt_q !== 2'd0 || protocol_err !== 1'b0) begin
      errors++; $display("FAIL perr_cnt: got cnt %0d err %b want 0 0", dut.cnt_q, protocol_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(2'b01, 1'b1, 1'b0); tick();
    drive(2'b10, 1'b0, 1'b0); tick();
    checks++;
    if (dut.lock_q !== 1'b1 || dut.cnt_q !== 2'd1 || dut.prio_q !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got lock %b cnt %0d prio %b want 1 1 1", dut.lock_q, dut.cnt_q, dut.prio_q);
    end
    m_req = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obi_req, m_gnt, m_rvalid, protocol_err, obi_addr} !== 38'b0) begin
      errors++; $display("FAIL mid_outputs: got %h want 0", {obi_req, m_gnt, m_rvalid, protocol_err, obi_addr});
    end
    checks++;
    if (dut.cnt_q !== 2'd0 || dut.prio_q !== 1'b0 || dut.lock_q !== 1'b0) begin
      errors++; $display("FAIL mid_state: got cnt %0d prio %b lock %b want 0 0 0", dut.cnt_q, dut.prio_q, dut.lock_q);
    end
    tick();
    rst_n = 1'b1;
    sb.delete();
    drive(2'b00, 1'b0, 1'b1);
    checks++;
    if (protocol_err !== 1'b1 || m_rvalid !== 2'b00) begin
      errors++; $display("FAIL mid_stale_rvalid: got err %b rvalid %b want 1 00", protocol_err, m_rvalid);
    end
    tick();
    obi_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
